// File: rtl/coeff_spi_loader_pkg.sv
// Shared types and constants for the biquad coefficient SPI loader.
// A coefficient bank holds one complete Q2.14 biquad set.
package coeff_pkg;

  typedef logic signed [15:0] coeff_t;

  typedef struct packed {
    coeff_t b0;
    coeff_t b1;
    coeff_t b2;
    coeff_t a1;
    coeff_t a2;
  } coeff_bank_t;

  localparam logic [7:0] CMD_LOAD    = 8'h01;
  localparam int         FRAME_BITS  = 88;
  localparam coeff_t     COEFF_UNITY = 16'sh4000;
  localparam coeff_t     RESET_B0    = COEFF_UNITY;

  // One past a full frame, so over-long frames stay distinguishable from exact ones
  localparam logic [6:0] COUNT_SAT   = 7'd89;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_COMMIT,
    ST_ERROR
  } state_t;

  function automatic coeff_bank_t reset_bank();
    coeff_bank_t bank;
    bank.b0 = RESET_B0;
    bank.b1 = '0;
    bank.b2 = '0;
    bank.a1 = '0;
    bank.a2 = '0;
    return bank;
  endfunction

  // Header occupies [87:80]; b0 follows immediately, a2 is the last word shifted in
  function automatic coeff_bank_t unpack_frame(input logic [FRAME_BITS-1:0] frame);
    coeff_bank_t bank;
    bank.b0 = frame[79:64];
    bank.b1 = frame[63:48];
    bank.b2 = frame[47:32];
    bank.a1 = frame[31:16];
    bank.a2 = frame[15:0];
    return bank;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI pin, with rise/fall detection
// on the synchronized level.
module spi_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Resetting to 0 means a chip select already low at reset release is never
  // mistaken for a fresh falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/coeff_spi_loader.sv
// SPI target that receives biquad coefficient frames into a pending bank and
// swaps them into the active outputs only on an audio sample boundary.
module coeff_spi_loader
  import coeff_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               sck,
  input  logic               sdi,
  input  logic               cs_n,
  input  logic               sample_strobe,
  output logic signed [15:0] b0,
  output logic signed [15:0] b1,
  output logic signed [15:0] b2,
  output logic signed [15:0] a1,
  output logic signed [15:0] a2,
  output logic               coeffs_valid,
  output logic               update_pulse,
  output logic               frame_error
);

  logic sck_level, sck_rise, sck_fall;
  logic sdi_level, sdi_rise, sdi_fall;
  logic cs_level, cs_rise, cs_fall;
  logic unused_sync;

  spi_sync_edge u_sync_sck (
    .clk   (clk),
    .reset (reset),
    .din   (sck),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge u_sync_sdi (
    .clk   (clk),
    .reset (reset),
    .din   (sdi),
    .level (sdi_level),
    .rise  (sdi_rise),
    .fall  (sdi_fall)
  );

  spi_sync_edge u_sync_cs (
    .clk   (clk),
    .reset (reset),
    .din   (cs_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  assign unused_sync = ^{sck_level, sck_fall, sdi_rise, sdi_fall};

  state_t                  state;
  logic [6:0]              bit_count;
  logic [FRAME_BITS-1:0]   shift_reg;
  coeff_bank_t             pending_bank;
  logic                    pending;
  coeff_bank_t             active_bank;
  logic                    apply;

  // Strobe uses the pending flag as it stood this cycle, so a same-cycle commit waits
  assign apply = sample_strobe & pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_count    <= '0;
      shift_reg    <= '0;
      pending_bank <= reset_bank();
      pending      <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      if (apply) begin
        pending <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            bit_count <= '0;
            shift_reg <= '0;
            state     <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (cs_rise) begin
            if (bit_count == 7'(FRAME_BITS) &&
                shift_reg[FRAME_BITS-1 -: 8] == CMD_LOAD) begin
              state <= ST_COMMIT;
            end else begin
              state <= ST_ERROR;
            end
          end else if (sck_rise && !cs_level) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], sdi_level};
            if (bit_count != COUNT_SAT) begin
              bit_count <= bit_count + 7'd1;
            end
          end
        end
        ST_COMMIT: begin
          pending_bank <= unpack_frame(shift_reg);
          pending      <= 1'b1;
          state        <= ST_IDLE;
        end
        ST_ERROR: begin
          frame_error <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The active bank only ever changes as a whole, at a sample boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_bank  <= reset_bank();
      coeffs_valid <= 1'b0;
      update_pulse <= 1'b0;
    end else begin
      update_pulse <= apply;
      if (apply) begin
        active_bank  <= pending_bank;
        coeffs_valid <= 1'b1;
      end
    end
  end

  assign b0 = active_bank.b0;
  assign b1 = active_bank.b1;
  assign b2 = active_bank.b2;
  assign a1 = active_bank.a1;
  assign a2 = active_bank.a2;

endmodule

// File: tb/tb_coeff_spi_loader.sv
// Self-checking bench for coeff_spi_loader: directed frames plus randomized
// frames compared against a bank-level reference model.
module tb_coeff_spi_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        sck;
  logic        sdi;
  logic        cs_n;
  logic        sample_strobe;
  logic [15:0] b0, b1, b2, a1, a2;
  logic        coeffs_valid;
  logic        update_pulse;
  logic        frame_error;

  int checks   = 0;
  int failures = 0;
  int upd_cnt  = 0;
  int err_cnt  = 0;
  int exp_upd  = 0;
  int exp_err  = 0;

  logic [15:0] m_active[5];
  logic [15:0] m_pending[5];
  bit          m_has_pending;
  bit          m_valid;

  always #5 clk = ~clk;

  coeff_spi_loader dut (
    .clk           (clk),
    .reset         (reset),
    .sck           (sck),
    .sdi           (sdi),
    .cs_n          (cs_n),
    .sample_strobe (sample_strobe),
    .b0            (b0),
    .b1            (b1),
    .b2            (b2),
    .a1            (a1),
    .a2            (a2),
    .coeffs_valid  (coeffs_valid),
    .update_pulse  (update_pulse),
    .frame_error   (frame_error)
  );

  // Every high cycle of a pulse output is counted, so a pulse wider than one clk shows up
  always @(negedge clk) begin
    if (update_pulse === 1'b1) upd_cnt++;
    if (frame_error === 1'b1) err_cnt++;
  end

  function automatic logic [127:0] makeFrame(input logic [7:0] hdr,
                                             input logic [15:0] c0, c1, c2, c3, c4);
    return {40'h0, hdr, c0, c1, c2, c3, c4};
  endfunction

  task automatic modelReset();
    m_active[0] = 16'h4000;
    for (int i = 1; i < 5; i++) m_active[i] = 16'h0000;
    for (int i = 0; i < 5; i++) m_pending[i] = 16'h0000;
    m_has_pending = 1'b0;
    m_valid       = 1'b0;
  endtask

  task automatic modelFrame(input logic [127:0] data, input int nbits);
    if (nbits == 88 && data[87:80] == 8'h01) begin
      for (int i = 0; i < 5; i++) m_pending[i] = data[79-16*i -: 16];
      m_has_pending = 1'b1;
    end else begin
      exp_err++;
    end
  endtask

  task automatic modelStrobe();
    if (m_has_pending) begin
      for (int i = 0; i < 5; i++) m_active[i] = m_pending[i];
      m_has_pending = 1'b0;
      m_valid       = 1'b1;
      exp_upd++;
    end
  endtask

  task automatic spiBit(input logic b);
    sdi = b;
    #50 sck = 1'b1;
    #50 sck = 1'b0;
  endtask

  // Returns right at the negedge on which cs_n is released
  task automatic spiSend(input logic [127:0] data, input int nbits);
    @(negedge clk);
    cs_n = 1'b0;
    #100;
    for (int i = nbits - 1; i >= 0; i--) spiBit(data[i]);
    #50;
    sdi = 1'b0;
    @(negedge clk);
    cs_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [127:0] data, input int nbits);
    spiSend(data, nbits);
    modelFrame(data, nbits);
    repeat (10) @(negedge clk);
  endtask

  task automatic pulseStrobe();
    @(negedge clk);
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    modelStrobe();
    repeat (3) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".b0"}, {16'h0, b0}, {16'h0, m_active[0]});
    checkOutput({tag, ".b1"}, {16'h0, b1}, {16'h0, m_active[1]});
    checkOutput({tag, ".b2"}, {16'h0, b2}, {16'h0, m_active[2]});
    checkOutput({tag, ".a1"}, {16'h0, a1}, {16'h0, m_active[3]});
    checkOutput({tag, ".a2"}, {16'h0, a2}, {16'h0, m_active[4]});
    checkOutput({tag, ".valid"}, {31'h0, coeffs_valid}, {31'h0, m_valid});
    checkOutput({tag, ".updates"}, upd_cnt, exp_upd);
    checkOutput({tag, ".errors"}, err_cnt, exp_err);
  endtask

  initial begin
    logic [127:0] data;
    logic [15:0]  c[5];
    logic [7:0]   hdr;
    int           nbits;
    int           kind;

    reset = 1'b1;
    sck = 1'b0;
    sdi = 1'b0;
    cs_n = 1'b1;
    sample_strobe = 1'b0;
    modelReset();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkAll("reset");

    // Idle with no traffic, including a strobe with nothing pending
    repeat (500) @(negedge clk);
    pulseStrobe();
    repeat (500) @(negedge clk);
    checkAll("idle");

    // Basic valid frame, strobe 50 clks after cs_n rise
    applyStimulus(makeFrame(8'h01, 16'h2000, 16'h4000, 16'h2000, 16'hC000, 16'h1000), 88);
    checkAll("load_before_strobe");
    repeat (40) @(negedge clk);
    pulseStrobe();
    checkAll("load_after_strobe");

    // Truncated frame, bad header, over-long frame, zero-bit cs glitch
    applyStimulus(makeFrame(8'h01, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555) >> 48, 40);
    checkAll("short_frame");
    pulseStrobe();
    checkAll("short_strobe");
    applyStimulus(makeFrame(8'h02, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555), 88);
    applyStimulus({makeFrame(8'h01, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555), 8'hA5}, 96);
    applyStimulus(128'h0, 0);
    pulseStrobe();
    checkAll("bad_frames");

    // Two valid frames before one strobe: the later one wins
    applyStimulus(makeFrame(8'h01, 16'h1000, 16'h0001, 16'h0002, 16'h0003, 16'h0004), 88);
    applyStimulus(makeFrame(8'h01, 16'h3000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0005), 88);
    pulseStrobe();
    checkAll("back_to_back");

    // Strobe landing on the commit cycle applies the older pending bank
    applyStimulus(makeFrame(8'h01, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 16'h0E0E), 88);
    data = makeFrame(8'h01, 16'h1A1A, 16'h1B1B, 16'h1C1C, 16'h1D1D, 16'h1E1E);
    spiSend(data, 88);
    repeat (3) @(negedge clk);
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    modelStrobe();
    modelFrame(data, 88);
    repeat (10) @(negedge clk);
    checkAll("strobe_on_commit");
    pulseStrobe();
    checkAll("strobe_after_commit");

    // Reset in the middle of a frame, released with cs_n still low
    data = makeFrame(8'h01, 16'h5A5A, 16'h6B6B, 16'h7C7C, 16'h8D8D, 16'h9E9E);
    @(negedge clk);
    cs_n = 1'b0;
    #100;
    for (int i = 87; i >= 38; i--) spiBit(data[i]);
    reset = 1'b1;
    modelReset();
    #30;
    reset = 1'b0;
    for (int i = 37; i >= 0; i--) spiBit(data[i]);
    #50;
    @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    checkAll("reset_mid_frame");
    pulseStrobe();
    checkAll("reset_strobe");
    applyStimulus(makeFrame(8'h01, 16'h1234, 16'hEDCB, 16'h0FF0, 16'hF00F, 16'h8000), 88);
    checkAll("post_reset_pending");
    pulseStrobe();
    checkAll("post_reset_apply");

    // Randomized frames of every kind against the model
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 5; i++) c[i] = 16'($urandom);
      if (k == 0) c[0] = 16'h8000;
      kind = (k == 0) ? 0 : int'($urandom_range(0, 3));
      case (kind)
        0: begin nbits = 88; data = makeFrame(8'h01, c[0], c[1], c[2], c[3], c[4]); end
        1: begin
             nbits = 88;
             hdr   = 8'($urandom_range(2, 255));
             data  = makeFrame(hdr, c[0], c[1], c[2], c[3], c[4]);
           end
        2: begin nbits = $urandom_range(1, 87); data = {$urandom, $urandom, $urandom, $urandom}; end
        default: begin
             nbits = $urandom_range(89, 120);
             data  = {$urandom, $urandom, $urandom, $urandom};
             data[87:80] = 8'h01;
           end
      endcase
      applyStimulus(data, nbits);
      checkAll($sformatf("rand%0d_frame", k));
      if ($urandom_range(0, 1) == 1) begin
        pulseStrobe();
        checkAll($sformatf("rand%0d_strobe", k));
      end
    end
    pulseStrobe();
    checkAll("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
